iter_divider: RTL and testbench
===============================

# iter_divider

Multi-cycle restoring divider for the single-cycle MIPS core, serving DIV and DIVU. It sits between the register-file read ports (Rs as dividend, Rt as divisor) and the HI/LO input muxes: quotient goes to LO and remainder goes to HI. The `busy` output stalls the PC while a division is in flight. It replaces a combinational divider with a WIDTH-step sequential datapath.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  request a division; sampled only when idle.
- sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
- abort  in  1  exception/ERET flush; cancels an in-flight division.
- dividend  in  WIDTH  Rs value; captured with start.
- divisor  in  WIDTH  Rt value; captured with start.
- busy  out  1  high while a division is in progress; drives the PC stall.
- done  out  1  one-cycle pulse; q and r are valid.
- q  out  WIDTH  quotient, for LO.
- r  out  WIDTH  remainder, for HI.

## Operation
- The state machine has three states: IDLE, RUN and FINISH.
- **IDLE**
  - On start=1, capture sign, |dividend|, |divisor| (absolute values only when sign=1), the negate-quotient flag, the negate-remainder flag and the divide-by-zero flag.
  - Clear the partial remainder, set the step counter to 0, go to RUN.
- **RUN**
  - Perform one restoring step per clock: shift {rem, quo} left 1, trial-subtract the divisor, keep the result if it is non-negative and set the quotient LSB.
  - The counter increments each step; after step WIDTH, go to FINISH.
- **FINISH**
  - Apply sign correction: q is negated iff sign=1 and the operand signs differ; r takes the sign of the dividend.
  - Register q and r, pulse done, go to IDLE.
- **Divide by zero:** q = all ones and r = the original dividend (raw, uncorrected). Latency is unchanged.
- **Signed overflow:** (−2^(WIDTH−1)) / −1 gives q = 0x80000000 and r = 0. This falls out of the unsigned-magnitude path and needs no special case.
- start while busy=1 is ignored.
- **abort** in RUN or FINISH: return to IDLE on the next edge. No done pulse. q and r keep their previous values. abort in IDLE has no effect.
- **Simultaneous abort and start in IDLE:** start wins.
- q and r hold their values until the next completed division.

## Timing
- start is sampled at edge E0.
- busy=1 from after E0 through the edge at E0+WIDTH+1. It falls at that edge, in the same edge where done rises.
- For WIDTH=32: q, r and done update at edge E0+33. done is high for exactly one cycle.
- The earliest back-to-back start is the cycle in which done is high (IDLE has already been re-entered). That start is sampled at E0+34.
- **Reset** (reset=0 at any edge, including mid-RUN): state goes to IDLE; busy, done, q, r and all internal registers go to 0.
- Reset has priority over abort and start.

## Structure
- Shared package cpu_pkg:
  - div_state_t enum (IDLE, RUN, FINISH).
  - DATA_W = 32 constant, used as the WIDTH default.
- One sub-module, div_step: purely combinational single restoring step. Inputs are rem, quo and divisor; outputs are next rem and next quo.
- The top module holds the FSM, the counter, the operand/sign registers and the output registers.
- The counter is $clog2(WIDTH)+1 bits.

## Test plan
1. DIVU 100 / 7 → q=14, r=2. done at E0+33. busy high for 33 cycles.
2. DIV 0xFFFFFFF9 / 2 (−7/2) → q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → q=0xFFFFFFFD, r=1.
3. DIV 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. DIVU with the same operands → q=0, r=0x80000000.
4. DIVU 0x1234 / 0 and DIV 0xFFFF0000 / 0 → q=0xFFFFFFFF, r equal to the dividend. done at E0+33.
5. Second start asserted at E0+5 is ignored; the result matches the first operands. abort at E0+10 → busy=0 next cycle, no done, q/r unchanged from the prior division.
6. reset=0 at E0+5 → busy/done/q/r all 0 after that edge. A new start (DIVU 9/3) one cycle after reset deasserts → q=3, r=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Types and constants shared by the MIPS core blocks.
package cpu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient LSB when it does not go negative.
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit holds the shifted-out remainder MSB; diff[WIDTH] is the borrow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient to LO (q), remainder to HI (r).
// busy stalls the PC while a division is in flight.
module iter_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic             dvd_neg, dvs_neg;
  logic             neg_q, neg_r, dz;

  assign dvd_neg = sign & dividend[WIDTH-1];
  assign dvs_neg = sign & divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dvs_abs = dvs_neg ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (abort) state_next = IDLE;
               else if (cnt == LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      q     <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rem   <= '0;
          quo   <= dvd_abs;
          dvsr  <= dvs_abs;
          cnt   <= '0;
          neg_q <= dvd_neg ^ dvs_neg;
          neg_r <= dvd_neg;
          dz    <= (divisor == '0);
        end
        RUN: if (!abort) begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 1'b1;
        end
        FINISH: if (!abort) begin
          // With a zero divisor the remainder path rebuilds |dividend|, so sign
          // correction alone returns the raw dividend; only q needs forcing.
          q    <= dz ? '1 : (neg_q ? -quo : quo);
          r    <= neg_r ? -rem : rem;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus random
// operands compared against a plain-arithmetic reference model.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] q, r;

  int n_checks = 0;
  int n_fail   = 0;

  iter_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sign     (sign),
    .abort    (abort),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er);
    longint sa, sb;
    if (b == 0) begin
      eq = '1;
      er = a;
    end else if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      eq = 32'(sa / sb);
      er = 32'(sa % sb);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  // Drives a start request; returns 1 time unit after the sampling edge E0.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    sign     = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Samples 1 time unit after edges E0..E0+40; lat = edge index where done seen (0 = never).
  // inj_k / abort_k place a one-edge start or abort pulse at edge E0+k (0 = none).
  task automatic track(input int inj_k, input int abort_k, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
      if (abort_k > 0 && k == abort_k) check("abort_busy", {31'b0, busy}, 32'd0);
      start = (k == inj_k - 1);
      if (start) begin
        dividend = $urandom;
        divisor  = $urandom_range(1, 9);
        sign     = ~sign;
      end
      abort = (k == abort_k - 1);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eq, er;
    int lat, bc;
    model(s, a, b, eq, er);
    launch(s, a, b);
    track(0, 0, lat, bc);
    check($sformatf("%s_q", tag), q, eq);
    check($sformatf("%s_r", tag), r, er);
    check($sformatf("%s_latency", tag), 32'(lat), 32'd33);
    check($sformatf("%s_busy_cycles", tag), 32'(bc), 32'd33);
  endtask

  initial begin
    logic [31:0] eq, er, pq, pr, a, b;
    logic        s;
    int          lat, bc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    check("done_at_b2b", {31'b0, done}, 32'd1);
    // Issued in the done cycle: the earliest back-to-back start.
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("busy_after_done", {31'b0, busy}, 32'd0);

    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
    do_div(1'b0, 32'h0000_1234, 32'd0, "divu_dz");
    do_div(1'b1, 32'hFFFF_0000, 32'd0, "div_dz");

    // start while busy is ignored
    model(1'b1, 32'hFFFF_FC18, 32'd7, eq, er);
    launch(1'b1, 32'hFFFF_FC18, 32'd7);
    track(5, 0, lat, bc);
    check("ignore_start_q", q, eq);
    check("ignore_start_r", r, er);
    check("ignore_start_latency", 32'(lat), 32'd33);

    // abort mid-run: no done, outputs keep the previous result
    pq = q;
    pr = r;
    launch(1'b0, 32'd555, 32'd3);
    track(0, 10, lat, bc);
    check("abort_no_done", 32'(lat), 32'd0);
    check("abort_busy_cycles", 32'(bc), 32'd10);
    check("abort_q_hold", q, pq);
    check("abort_r_hold", r, pr);

    // abort together with start in IDLE: start wins
    abort = 1'b1;
    do_div(1'b0, 32'd1000, 32'd9, "abort_start_idle");

    // reset mid-run
    launch(1'b0, 32'd50, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_q", q, 32'd0);
    check("midrst_r", r, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_div(1'b0, 32'd9, 32'd3, "post_rst");

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       b = $urandom >> $urandom_range(1, 30);
        default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'hFFFF_FFFF;
      endcase
      do_div(s, a, b, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
